// File: rtl/point_subtractor.sv
// point_subtractor
// Sequential elliptic-curve point subtractor over GF(2^7) on the binary curve
// y^2 + xy = x^3 + x^2 + 1. Computes diff = point1 - point2 by adding the
// negation of point2, where -(x,y) = (x, x^y). One squarer and one multiplier
// are shared across all steps. The field inverse is z^126, built by iterative
// exponentiation. Every request takes the same fixed latency, including the
// trivial infinity/identity cases.
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous active-high reset; aborts any operation in flight
//   start   request pulse, only honoured in IDLE while done is low
//   point1  minuend    {y[13:7], x[6:0]}, 14'b0 is the point at infinity
//   point2  subtrahend {y[13:7], x[6:0]}
//   busy    high from the cycle after start is accepted until the done cycle
//   done    one-cycle pulse when diff has been updated
//   diff    result {y3, x3}, held until the next completed request

module point_subtractor #(
    parameter logic [6:0] FIELD_POLY = 7'b0000011
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [13:0] point1,
    input  logic [13:0] point2,
    output logic        busy,
    output logic        done,
    output logic [13:0] diff
);

    typedef enum logic [2:0] {
        IDLE,
        INV,
        SLOPE,
        X3,
        Y3,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        KIND_NEG_P2,
        KIND_P1,
        KIND_GENERAL,
        KIND_INFINITY,
        KIND_DOUBLE
    } kind_t;

    // Fold a 13-bit carry-less product back into the field using x^7 == FIELD_POLY.
    function automatic logic [6:0] gfReduce(input logic [12:0] v);
        logic [12:0] t;
        t = v;
        for (int i = 12; i >= 7; i--) begin
            if (t[i]) begin
                t[i] = 1'b0;
                t    = t ^ ({6'b0, FIELD_POLY} << (i - 7));
            end
        end
        return t[6:0];
    endfunction

    function automatic logic [6:0] gfMul(input logic [6:0] a, input logic [6:0] b);
        logic [12:0] p;
        p = '0;
        for (int i = 0; i < 7; i++) begin
            if (b[i]) begin
                p = p ^ ({6'b0, a} << i);
            end
        end
        return gfReduce(p);
    endfunction

    // Squaring in characteristic 2 just spreads the bits apart before reduction.
    function automatic logic [6:0] gfSquare(input logic [6:0] a);
        logic [12:0] s;
        s = '0;
        for (int i = 0; i < 7; i++) begin
            s[2*i] = a[i];
        end
        return gfReduce(s);
    endfunction

    state_t      r_state;
    state_t      w_nextState;
    kind_t       r_kind;
    kind_t       w_kind;
    logic [2:0]  r_count;
    logic [6:0]  r_x1, r_y1, r_x2, r_y2n;
    logic [6:0]  r_z, r_inv, r_lambda, r_x3, r_y3;
    logic        r_done;
    logic [13:0] r_diff;

    logic        w_accept;
    logic [6:0]  w_inX1, w_inY1, w_inX2, w_inY2, w_inZ;
    logic [6:0]  w_sqIn, w_sqOut, w_mulA, w_mulB, w_mulOut;

    assign w_inX1 = point1[6:0];
    assign w_inY1 = point1[13:7];
    assign w_inX2 = point2[6:0];
    assign w_inY2 = point2[13:7];

    // A request completing this cycle still has done high; a start seen then
    // must wait for the following IDLE cycle.
    assign w_accept = (r_state == IDLE) && start && !r_done;

    // Classify the request at capture time. Trivial cases still run the full
    // pipeline so the latency never depends on the operands.
    always_comb begin
        w_kind = KIND_GENERAL;
        w_inZ  = w_inX1 ^ w_inX2;
        if (point1 == 14'b0) begin
            w_kind = KIND_NEG_P2;
        end else if (point2 == 14'b0) begin
            w_kind = KIND_P1;
        end else if (w_inX1 != w_inX2) begin
            w_kind = KIND_GENERAL;
        end else if (w_inY1 == w_inY2) begin
            w_kind = KIND_INFINITY;
        end else if (w_inX1 == 7'd0) begin
            w_kind = KIND_INFINITY;
        end else begin
            w_kind = KIND_DOUBLE;
            w_inZ  = w_inX1;
        end
    end

    // Squarer input select: the running power during inversion, lambda for
    // x3, and x1 for the doubling y3 term.
    always_comb begin
        w_sqIn = r_inv;
        case (r_state)
            X3:      w_sqIn = r_lambda;
            Y3:      w_sqIn = r_x1;
            default: w_sqIn = r_inv;
        endcase
    end

    assign w_sqOut = gfSquare(w_sqIn);

    // Multiplier operand select for each step of the computation.
    always_comb begin
        w_mulA = w_sqOut;
        w_mulB = r_z;
        case (r_state)
            SLOPE: begin
                w_mulA = (r_kind == KIND_DOUBLE) ? r_y1 : (r_y1 ^ r_y2n);
                w_mulB = r_inv;
            end
            Y3: begin
                if (r_kind == KIND_DOUBLE) begin
                    w_mulA = r_lambda ^ 7'd1;
                    w_mulB = r_x3;
                end else begin
                    w_mulA = r_lambda;
                    w_mulB = r_x1 ^ r_x3;
                end
            end
            default: begin
                w_mulA = w_sqOut;
                w_mulB = r_z;
            end
        endcase
    end

    assign w_mulOut = gfMul(w_mulA, w_mulB);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: inversion holds for six cycles, every other step is one.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    w_nextState = w_accept ? INV : IDLE;
            INV:     w_nextState = (r_count == 3'd5) ? SLOPE : INV;
            SLOPE:   w_nextState = X3;
            X3:      w_nextState = Y3;
            Y3:      w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Output logic: busy covers every non-IDLE state, so it drops exactly as
    // the registered done pulse appears.
    always_comb begin
        busy = (r_state != IDLE);
    end

    // Datapath: operand capture, inversion chain, slope, x3, y3 and result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_kind   <= KIND_NEG_P2;
            r_count  <= 3'd0;
            r_x1     <= 7'd0;
            r_y1     <= 7'd0;
            r_x2     <= 7'd0;
            r_y2n    <= 7'd0;
            r_z      <= 7'd0;
            r_inv    <= 7'd0;
            r_lambda <= 7'd0;
            r_x3     <= 7'd0;
            r_y3     <= 7'd0;
            r_done   <= 1'b0;
            r_diff   <= 14'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_kind  <= w_kind;
                        r_count <= 3'd0;
                        r_x1    <= w_inX1;
                        r_y1    <= w_inY1;
                        r_x2    <= w_inX2;
                        r_y2n   <= w_inX2 ^ w_inY2;
                        r_z     <= w_inZ;
                        r_inv   <= w_inZ;
                    end
                end
                INV: begin
                    // Five square-and-multiply steps reach z^63, a final
                    // square gives z^126 = z^-1 (and 0 stays 0).
                    r_count <= r_count + 3'd1;
                    r_inv   <= (r_count == 3'd5) ? w_sqOut : w_mulOut;
                end
                SLOPE: begin
                    r_lambda <= (r_kind == KIND_DOUBLE) ? (r_x1 ^ w_mulOut) : w_mulOut;
                end
                X3: begin
                    if (r_kind == KIND_DOUBLE) begin
                        r_x3 <= w_sqOut ^ r_lambda ^ 7'd1;
                    end else begin
                        r_x3 <= w_sqOut ^ r_lambda ^ r_x1 ^ r_x2 ^ 7'd1;
                    end
                end
                Y3: begin
                    if (r_kind == KIND_DOUBLE) begin
                        r_y3 <= w_sqOut ^ w_mulOut;
                    end else begin
                        r_y3 <= w_mulOut ^ r_x3 ^ r_y1;
                    end
                end
                DONE: begin
                    r_done <= 1'b1;
                    case (r_kind)
                        KIND_NEG_P2:   r_diff <= {r_y2n, r_x2};
                        KIND_P1:       r_diff <= {r_y1, r_x1};
                        KIND_INFINITY: r_diff <= 14'b0;
                        default:       r_diff <= {r_y3, r_x3};
                    endcase
                end
                default: begin
                    r_count <= 3'd0;
                end
            endcase
        end
    end

    assign done = r_done;
    assign diff = r_diff;

endmodule

// File: tb/tb_point_subtractor.sv
// tb_point_subtractor
// Self-checking bench for point_subtractor: directed vectors, randomized
// requests against a behavioural model, handshake corner cases and a
// mid-operation reset.

module tb_point_subtractor;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [13:0] point1;
    logic [13:0] point2;
    logic        busy;
    logic        done;
    logic [13:0] diff;

    int nChecks = 0;
    int nPass   = 0;

    point_subtractor dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .point1 (point1),
        .point2 (point2),
        .busy   (busy),
        .done   (done),
        .diff   (diff)
    );

    always #5 clk = ~clk;

    // Field multiply by shift-and-add with x^7 = x + 1 folded in as we go.
    function automatic logic [6:0] mMul(input logic [6:0] a, input logic [6:0] b);
        logic [7:0] aa;
        logic [6:0] bb;
        logic [6:0] res;
        res = '0;
        aa  = {1'b0, a};
        bb  = b;
        for (int i = 0; i < 7; i++) begin
            if (bb[0]) res = res ^ aa[6:0];
            bb = bb >> 1;
            aa = aa << 1;
            if (aa[7]) aa = aa ^ 8'h83;
        end
        return res;
    endfunction

    // Inverse by exhaustive search over the 127 nonzero elements.
    function automatic logic [6:0] mInv(input logic [6:0] a);
        logic [6:0] cand;
        if (a == 7'd0) return 7'd0;
        for (int b = 1; b < 128; b++) begin
            cand = 7'(b);
            if (mMul(a, cand) == 7'd1) return cand;
        end
        return 7'd0;
    endfunction

    // Point subtraction straight from the curve formulas.
    function automatic logic [13:0] mSub(input logic [13:0] p1, input logic [13:0] p2);
        logic [6:0] x1, y1, x2, y2, l, x3, y3;
        x1 = p1[6:0];
        y1 = p1[13:7];
        x2 = p2[6:0];
        y2 = p2[13:7];
        if (p1 == 14'b0) return {x2 ^ y2, x2};
        if (p2 == 14'b0) return p1;
        if (x1 != x2) begin
            l  = mMul(y1 ^ x2 ^ y2, mInv(x1 ^ x2));
            x3 = mMul(l, l) ^ l ^ x1 ^ x2 ^ 7'd1;
            y3 = mMul(l, x1 ^ x3) ^ x3 ^ y1;
            return {y3, x3};
        end
        if (y1 == y2) return 14'b0;
        if (x1 == 7'd0) return 14'b0;
        l  = x1 ^ mMul(y1, mInv(x1));
        x3 = mMul(l, l) ^ l ^ 7'd1;
        y3 = mMul(x1, x1) ^ mMul(l ^ 7'd1, x3);
        return {y3, x3};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for done; returns the number of edges waited.
    task automatic waitDone(output int n);
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    // One full request: latency, handshake, result and hold are all checked.
    task automatic applyStimulus(input logic [13:0] p1, input logic [13:0] p2,
                                 input logic [13:0] expDiff, input string tag);
        int n;
        @(negedge clk);
        point1 = p1;
        point2 = p2;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        point1 = 14'($urandom);
        point2 = 14'($urandom);
        checkOutput({tag, ".busy"}, busy, 1);
        waitDone(n);
        checkOutput({tag, ".latency"}, n, 10);
        checkOutput({tag, ".diff"}, diff, expDiff);
        checkOutput({tag, ".busyInDone"}, busy, 0);
        @(posedge clk);
        #1;
        checkOutput({tag, ".donePulse"}, done, 0);
        checkOutput({tag, ".hold"}, diff, expDiff);
    endtask

    initial begin
        int n;
        int pulses;
        logic [13:0] p1, p2;
        int mode;

        reset  = 1'b1;
        start  = 1'b0;
        point1 = 14'b0;
        point2 = 14'b0;
        #12;
        checkOutput("reset.busy", busy, 0);
        checkOutput("reset.done", done, 0);
        checkOutput("reset.diff", diff, 0);
        @(negedge clk);
        reset = 1'b0;

        // Directed vectors with hand-derived results.
        applyStimulus(14'b0, {7'h05, 7'h03}, 14'h0303, "negP2");
        applyStimulus({7'h00, 7'h03}, 14'b0, 14'h0003, "identity");
        applyStimulus({7'h04, 7'h02}, {7'h04, 7'h02}, 14'h0000, "self");
        applyStimulus({7'h00, 7'h03}, {7'h03, 7'h01}, 14'h0183, "lambdaOne");
        applyStimulus({7'h00, 7'h03}, {7'h00, 7'h01}, 14'h19A3, "general");
        applyStimulus({7'h00, 7'h01}, {7'h01, 7'h01}, 14'h0081, "double");
        applyStimulus({7'h05, 7'h00}, {7'h09, 7'h00}, 14'h0000, "doubleX0");

        // Randomized requests, biased toward the special cases.
        for (int i = 0; i < 40; i++) begin
            p1   = 14'($urandom);
            p2   = 14'($urandom);
            mode = $urandom_range(0, 9);
            case (mode)
                0: p1 = 14'b0;
                1: p2 = 14'b0;
                2: p2 = p1;
                3: p2 = {7'($urandom), p1[6:0]};
                4: begin p1[6:0] = 7'd0; p2[6:0] = 7'd0; end
                default: ;
            endcase
            applyStimulus(p1, p2, mSub(p1, p2), "random");
        end

        // A start pulse while busy must not produce a second completion.
        @(negedge clk);
        point1 = {7'h00, 7'h03};
        point2 = {7'h03, 7'h01};
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        point1 = {7'h00, 7'h03};
        point2 = {7'h00, 7'h01};
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        pulses = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        checkOutput("busyStart.pulses", pulses, 1);
        checkOutput("busyStart.diff", diff, 14'h0183);

        // A start held through the done cycle is taken on the next IDLE cycle.
        @(negedge clk);
        point1 = {7'h00, 7'h03};
        point2 = {7'h03, 7'h01};
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(n);
        checkOutput("doneStart.firstLatency", n, 10);
        start  = 1'b1;
        point1 = {7'h00, 7'h03};
        point2 = {7'h00, 7'h01};
        @(posedge clk);
        #1;
        checkOutput("doneStart.ignored", busy, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("doneStart.accepted", busy, 1);
        waitDone(n);
        checkOutput("doneStart.latency", n, 10);
        checkOutput("doneStart.diff", diff, 14'h19A3);
        @(posedge clk);
        #1;

        // Reset in the middle of a request clears everything and suppresses done.
        @(negedge clk);
        point1 = {7'h00, 7'h01};
        point2 = {7'h01, 7'h01};
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("midReset.busy", busy, 0);
        checkOutput("midReset.done", done, 0);
        checkOutput("midReset.diff", diff, 0);
        @(negedge clk);
        reset  = 1'b0;
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            if (done || busy) pulses++;
        end
        checkOutput("midReset.quiet", pulses, 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
